// File: rtl/usb_tx_sched.sv
// USB device TX packet scheduler: arbitrates handshake/data requesters and streams PID, payload and CRC bytes.
// Optional USB_TX_CRC16_EN: generate CRC16 internally instead of taking the two CRC bytes from the requester.
module usb_tx_sched #(
    parameter int MAX_PAYLOAD = 64,
    parameter int TURNAROUND  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       usb_reset,
    input  logic       rx_active,
    input  logic       hs_req,
    input  logic [3:0] hs_pid,
    output logic       hs_gnt,
    input  logic       dat_req,
    input  logic       dat_pid1,
    input  logic [9:0] dat_len,
    input  logic [7:0] dat_data,
    output logic       dat_rd,
    output logic       dat_done,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, GAP, PID, DATA, CRC_LO, CRC_HI} state_t;

    localparam int            GW       = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (TURNAROUND > 0) ? GW'(TURNAROUND - 1) : '0;
    localparam logic [9:0]    MAX_LEN  = 10'(MAX_PAYLOAD);

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [3:0]    pid_q, pid_d;
    logic          hs_q, hs_d;
    logic          gnt_d, done_d;
    logic          xfer;

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_q, crc_d;

    // Reflected CRC16 (0x8005 -> 0xA001), data bits taken LSB first as on the wire.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    assign xfer = tx_valid & tx_ready;
    assign busy = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        pid_d    = pid_q;
        hs_d     = hs_q;
        gnt_d    = 1'b0;
        done_d   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dat_rd   = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_d    = crc_q;
`endif
        case (state_q)
            IDLE: begin
                if (hs_req) begin
                    state_d = GAP;
                    hs_d    = 1'b1;
                    pid_d   = hs_pid;
                    gap_d   = GAP_LOAD;
                end else if (dat_req) begin
                    state_d = GAP;
                    hs_d    = 1'b0;
                    pid_d   = dat_pid1 ? 4'b1011 : 4'b0011;
                    gap_d   = GAP_LOAD;
                    cnt_d   = (dat_len > MAX_LEN) ? MAX_LEN : dat_len;
`ifdef USB_TX_CRC16_EN
                    crc_d   = 16'hFFFF;
`endif
                end
            end
            GAP: begin
                if (rx_active)         gap_d   = GAP_LOAD;
                else if (gap_q == '0)  state_d = PID;
                else                   gap_d   = gap_q - 1'b1;
            end
            PID: begin
                tx_valid = 1'b1;
                tx_data  = {~pid_q, pid_q};
                if (xfer) begin
                    if (hs_q) begin
                        state_d = IDLE;
                        gnt_d   = 1'b1;
                    end else begin
                        state_d = (cnt_q == '0) ? CRC_LO : DATA;
                    end
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = dat_data;
                if (xfer) begin
                    dat_rd = 1'b1;
                    cnt_d  = cnt_q - 1'b1;
`ifdef USB_TX_CRC16_EN
                    crc_d  = crc_byte(crc_q, dat_data);
`endif
                    if (cnt_q == 10'd1) state_d = CRC_LO;
                end
            end
            CRC_LO: begin
                tx_valid = 1'b1;
`ifdef USB_TX_CRC16_EN
                tx_data  = ~crc_q[7:0];
`else
                tx_data  = dat_data;
                dat_rd   = xfer;
`endif
                if (xfer) state_d = CRC_HI;
            end
            CRC_HI: begin
                tx_valid = 1'b1;
`ifdef USB_TX_CRC16_EN
                tx_data  = ~crc_q[15:8];
`else
                tx_data  = dat_data;
                dat_rd   = xfer;
`endif
                if (xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus reset aborts whatever is in flight without completion pulses.
        if (usb_reset) begin
            state_d = IDLE;
            gnt_d   = 1'b0;
            done_d  = 1'b0;
            gap_d   = '0;
            cnt_d   = '0;
`ifdef USB_TX_CRC16_EN
            crc_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            cnt_q    <= '0;
            pid_q    <= '0;
            hs_q     <= 1'b0;
            hs_gnt   <= 1'b0;
            dat_done <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            pid_q    <= pid_d;
            hs_q     <= hs_d;
            hs_gnt   <= gnt_d;
            dat_done <= done_d;
`ifdef USB_TX_CRC16_EN
            crc_q    <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched; expectations adapt to whether USB_TX_CRC16_EN is defined.
module tb_usb_tx_sched;

    localparam int MAXP = 4;
    localparam int TURN = 3;
`ifdef USB_TX_CRC16_EN
    localparam int RD_EXTRA = 0;
`else
    localparam int RD_EXTRA = 2;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       usb_reset = 1'b0;
    logic       rx_active = 1'b0;
    logic       hs_req = 1'b0;
    logic [3:0] hs_pid = 4'h0;
    logic       hs_gnt;
    logic       dat_req = 1'b0;
    logic       dat_pid1 = 1'b0;
    logic [9:0] dat_len = 10'd0;
    logic [7:0] dat_data;
    logic       dat_rd;
    logic       dat_done;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;

    int errors = 0;
    int checks = 0;

    usb_tx_sched #(.MAX_PAYLOAD(MAXP), .TURNAROUND(TURN)) dut (
        .clk(clk), .reset_n(reset_n), .usb_reset(usb_reset), .rx_active(rx_active),
        .hs_req(hs_req), .hs_pid(hs_pid), .hs_gnt(hs_gnt),
        .dat_req(dat_req), .dat_pid1(dat_pid1), .dat_len(dat_len), .dat_data(dat_data),
        .dat_rd(dat_rd), .dat_done(dat_done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Data requester: presents pbuf[n] where n counts consumed bytes of the current packet.
    logic [7:0] pbuf [0:15];
    int rd_cnt = 0;
    int rd_base = 0;
    assign dat_data = pbuf[4'(rd_cnt - rd_base)];
    always @(posedge clk) if (dat_rd) rd_cnt <= rd_cnt + 1;

    logic [7:0] rec[$];
    int gnt_cnt = 0, done_cnt = 0, rdp_cnt = 0, starts = 0, vcyc = 0, bcyc = 0;
    int stab_err = 0, gnt_err = 0;
    logic prev_v = 1'b0, prev_x = 1'b0;
    logic [7:0] prev_d = 8'h00;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) rec.push_back(tx_data);
        if (tx_valid && !prev_v) starts++;
        if (tx_valid) vcyc++;
        if (busy) bcyc++;
        if (prev_v && !prev_x && tx_valid && (tx_data !== prev_d)) stab_err++;
        if (hs_gnt) begin
            gnt_cnt++;
            if (tx_valid) gnt_err++;
        end
        if (dat_done) done_cnt++;
        if (dat_rd) rdp_cnt++;
        prev_v = tx_valid;
        prev_x = tx_valid && tx_ready;
        prev_d = tx_data;
    end

    int s_gnt, s_done, s_rdp, s_starts, s_vcyc, s_bcyc, s_rec;
    logic [7:0] expb [0:15];
    int expn;

    task automatic snap();
        s_gnt = gnt_cnt; s_done = done_cnt; s_rdp = rdp_cnt;
        s_starts = starts; s_vcyc = vcyc; s_bcyc = bcyc; s_rec = rec.size();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bytes(input string tag);
        chk({tag, "_nbytes"}, rec.size() - s_rec, expn);
        for (int i = 0; i < expn; i++)
            chk($sformatf("%s_b%0d", tag, i), rec[s_rec + i], expb[i]);
    endtask

    // Golden CRC16 in the non-reflected MSB-first form, bit-reversed at the end.
    function automatic logic [15:0] golden_crc(input int n);
        logic [15:0] c, r;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[15] ^ pbuf[i][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        c = ~c;
        for (int k = 0; k < 16; k++) r[k] = c[15 - k];
        return r;
    endfunction

    task automatic wait_pkt(input int maxc, input bit toggle);
        int c;
        c = 0;
        do begin
            @(posedge clk); #1;
            if (toggle) tx_ready = ~tx_ready;
            c++;
        end while (busy && c < maxc);
        chk("pkt_timeout", 32'(c < maxc), 1);
        if (hs_gnt) hs_req = 1'b0;
        if (dat_done) dat_req = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic load_payload(input int n, input logic [7:0] first);
        logic [15:0] crc;
        for (int i = 0; i < n; i++) pbuf[i] = first + 8'(i);
        crc = golden_crc(n);
        pbuf[n]     = crc[7:0];
        pbuf[n + 1] = crc[15:8];
        rd_base = rd_cnt;
    endtask

    initial begin
        int n, k;
        logic [15:0] crc;
        for (int i = 0; i < 16; i++) pbuf[i] = 8'h00;
        tx_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_hs_gnt", hs_gnt, 0);
        chk("rst_dat_rd", dat_rd, 0);
        chk("rst_dat_done", dat_done, 0);

        // Handshake ACK, granted on the first edge after reset release
        @(posedge clk); #1;
        reset_n = 1'b1; hs_req = 1'b1; hs_pid = 4'b0010;
        snap();
        @(posedge clk); #1;
        chk("first_grant_busy", busy, 1);
        wait_pkt(50, 1'b0);
        expb[0] = 8'hD2; expn = 1;
        chk_bytes("ack");
        chk("ack_valid_cycles", vcyc - s_vcyc, 1);
        chk("ack_busy_cycles", bcyc - s_bcyc, TURN + 1);
        chk("ack_gnt", gnt_cnt - s_gnt, 1);
        chk("ack_gnt_overlap", gnt_err, 0);

        // Zero-length DATA1
        snap();
        load_payload(0, 8'h00);
        dat_pid1 = 1'b1; dat_len = 10'd0; dat_req = 1'b1;
        wait_pkt(50, 1'b0);
        expb[0] = 8'h4B; expb[1] = 8'h00; expb[2] = 8'h00; expn = 3;
        chk_bytes("zlp");
        chk("zlp_starts", starts - s_starts, 1);
        chk("zlp_valid_cycles", vcyc - s_vcyc, 3);
        chk("zlp_done", done_cnt - s_done, 1);
        chk("zlp_rd", rdp_cnt - s_rdp, RD_EXTRA);

        // DATA0 00 01 02 03 with tx_ready toggling
        snap();
        load_payload(4, 8'h00);
        crc = golden_crc(4);
        dat_pid1 = 1'b0; dat_len = 10'd4; dat_req = 1'b1;
        wait_pkt(100, 1'b1);
        tx_ready = 1'b1;
        expb[0] = 8'hC3; expb[1] = 8'h00; expb[2] = 8'h01; expb[3] = 8'h02; expb[4] = 8'h03;
        expb[5] = crc[7:0]; expb[6] = crc[15:8]; expn = 7;
        chk_bytes("d4");
        chk("d4_starts", starts - s_starts, 1);
        chk("d4_stable", stab_err, 0);
        chk("d4_rd", rdp_cnt - s_rdp, 4 + RD_EXTRA);
        chk("d4_done", done_cnt - s_done, 1);

        // Length above MAX_PAYLOAD is clamped
        snap();
        load_payload(MAXP, 8'h20);
        crc = golden_crc(MAXP);
        dat_pid1 = 1'b1; dat_len = 10'd7; dat_req = 1'b1;
        wait_pkt(100, 1'b0);
        expb[0] = 8'h4B; expb[1] = 8'h20; expb[2] = 8'h21; expb[3] = 8'h22; expb[4] = 8'h23;
        expb[5] = crc[7:0]; expb[6] = crc[15:8]; expn = 7;
        chk_bytes("clamp");
        chk("clamp_rd", rdp_cnt - s_rdp, MAXP + RD_EXTRA);

        // Simultaneous requests: handshake first, data request stays pending
        snap();
        pbuf[0] = 8'hAA;
        crc = golden_crc(1);
        pbuf[1] = crc[7:0]; pbuf[2] = crc[15:8];
        rd_base = rd_cnt;
        hs_pid = 4'b1010; hs_req = 1'b1;
        dat_pid1 = 1'b0; dat_len = 10'd1; dat_req = 1'b1;
        wait_pkt(50, 1'b0);
        expb[0] = 8'h5A; expn = 1;
        chk_bytes("both_hs");
        chk("both_hs_gnt", gnt_cnt - s_gnt, 1);
        chk("both_hs_done", done_cnt - s_done, 0);
        snap();
        wait_pkt(50, 1'b0);
        expb[0] = 8'hC3; expb[1] = 8'hAA; expb[2] = crc[7:0]; expb[3] = crc[15:8]; expn = 4;
        chk_bytes("both_dat");
        chk("both_dat_done", done_cnt - s_done, 1);
        chk("both_dat_gnt", gnt_cnt - s_gnt, 0);

        // rx_active holds off the packet; TURN idle cycles after it falls
        snap();
        hs_pid = 4'b1110; hs_req = 1'b1; rx_active = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rx_hold_busy", busy, 1);
        chk("rx_hold_no_valid", vcyc - s_vcyc, 0);
        rx_active = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (tx_valid) break;
            @(posedge clk);
            n++;
        end
        chk("rx_turnaround", n, TURN);
        wait_pkt(20, 1'b0);
        expb[0] = 8'h1E; expn = 1;
        chk_bytes("stall");
        chk("stall_gnt", gnt_cnt - s_gnt, 1);

        // Bus reset after the second payload byte, then a clean packet
        snap();
        load_payload(4, 8'h10);
        crc = golden_crc(4);
        dat_pid1 = 1'b1; dat_len = 10'd4; dat_req = 1'b1;
        k = 0;
        while (k < 100) begin
            @(posedge clk); #1;
            if (rd_cnt - rd_base >= 2) break;
            k++;
        end
        chk("ureset_reach", 32'(k < 100), 1);
        usb_reset = 1'b1; dat_req = 1'b0;
        @(posedge clk); #1;
        usb_reset = 1'b0;
        @(negedge clk);
        chk("ureset_valid", tx_valid, 0);
        chk("ureset_busy", busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("ureset_no_done", done_cnt - s_done, 0);
        chk("ureset_no_gnt", gnt_cnt - s_gnt, 0);
        snap();
        rd_base = rd_cnt;
        dat_req = 1'b1;
        wait_pkt(100, 1'b0);
        expb[0] = 8'h4B; expb[1] = 8'h10; expb[2] = 8'h11; expb[3] = 8'h12; expb[4] = 8'h13;
        expb[5] = crc[7:0]; expb[6] = crc[15:8]; expn = 7;
        chk_bytes("after_ureset");
        chk("after_ureset_done", done_cnt - s_done, 1);
        chk("after_ureset_rd", rdp_cnt - s_rdp, 4 + RD_EXTRA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_tx_sched.md
USB_TX_SCHED -- requirements
Module: usb_tx_sched

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 64, maximum DATA payload bytes (1..1023).
REQ-002 SHALL have parameter TURNAROUND, default 2, idle clk cycles required after rx_active falls before the first PID byte.
REQ-003 SHALL have port clk  in  1  transceiver clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port usb_reset  in  1  bus reset from the transceiver; synchronous abort.
REQ-006 SHALL have port rx_active  in  1  receiver busy; blocks packet start.
REQ-007 SHALL have ports hs_req in 1, hs_pid in 4, hs_gnt out 1: handshake requester (ACK/NAK/STALL PID; gnt is a 1-cycle pulse after the PID byte transfers).
REQ-008 SHALL have ports dat_req in 1, dat_pid1 in 1, dat_len in 10, dat_data in 8, dat_rd out 1, dat_done out 1: data requester (DATA0/DATA1, length, payload byte, per-byte consume pulse, end pulse).
REQ-009 SHALL have ports tx_data out 8, tx_valid out 1, tx_ready in 1: byte stream to the transceiver TX.
REQ-010 SHALL have port busy  out 1  high in every state except IDLE.

Function
- REQ-011 SHALL implement the FSM states IDLE, GAP, PID, DATA, CRC_LO, CRC_HI.
- REQ-012 A byte transfers only on a cycle with tx_valid&tx_ready; while tx_valid is high, tx_data SHALL stay stable until that cycle.
- REQ-013 IDLE SHALL sample the requests; hs_req SHALL have fixed priority over dat_req, and the loser SHALL stay pending (requests are level, held until gnt/done).
- REQ-014 IDLE->GAP on a granted request; GAP SHALL count TURNAROUND cycles with rx_active low, restarting the count whenever rx_active is high; then GAP->PID.
- REQ-015 The PID byte SHALL be {~pid[3:0], pid[3:0]}; DATA0 pid=4'b0011 (0xC3), DATA1 pid=4'b1011 (0x4B).
- REQ-016 Handshake path: PID->IDLE after the transfer, tx_valid low the next cycle, and hs_gnt pulsed that cycle.
- REQ-017 Data path: PID->DATA if dat_len>0, else PID->CRC_LO; dat_len SHALL be latched at grant, and values >MAX_PAYLOAD SHALL be clamped to MAX_PAYLOAD.
- REQ-018 In DATA, tx_data SHALL equal dat_data; dat_rd SHALL pulse on each transfer; after the latched count of bytes, DATA->CRC_LO.
- REQ-019 CRC_LO then CRC_HI SHALL each send one byte; after the CRC_HI transfer: ->IDLE, tx_valid low, dat_done pulsed.
- REQ-020 tx_valid SHALL stay continuously high from the PID byte through the last byte of a packet (no gaps, so the transmitter does not emit a premature EOP).
- REQ-021 tx_ready while tx_valid is low SHALL be ignored.
- REQ-022 usb_reset high in any state SHALL force IDLE on the next edge: tx_valid low, no hs_gnt/dat_done, and the latched length and CRC cleared.
- REQ-023 hs_req arriving during a data packet SHALL NOT preempt it.

Reset
- REQ-024 reset_n low SHALL asynchronously set: state IDLE, tx_valid=0, tx_data=8'h00, hs_gnt=0, dat_rd=0, dat_done=0, busy=0, and the GAP counter, byte counter and CRC register to 0.
- REQ-025 After reset_n deasserts, the first grant SHALL be possible on the first edge.

Configuration
- REQ-026 Macro USB_TX_CRC16_EN defined: CRC16 (poly 0x8005, reflected, init 0xFFFF, output complemented) SHALL be computed over the payload and sent low byte first in CRC_LO/CRC_HI.
- REQ-027 Macro USB_TX_CRC16_EN undefined: the CRC logic SHALL be removed, CRC_LO/CRC_HI SHALL send dat_data with dat_rd pulses, and the requester supplies the two CRC bytes (dat_len excludes them).

Verification
- REQ-028 hs_req=1, hs_pid=4'b0010, tx_ready always 1 -> tx_data 0xD2 with a single tx_valid cycle after TURNAROUND idle cycles, then one hs_gnt pulse.
- REQ-029 dat_req=1, dat_pid1=1, dat_len=0, USB_TX_CRC16_EN defined -> bytes 0x4B, 0x00, 0x00 with contiguous tx_valid, one dat_done, zero dat_rd.
- REQ-030 dat_len=4, payload 00 01 02 03, tx_ready toggling every other cycle -> C3 00 01 02 03 + CRC matching the golden model, tx_data stable while stalled, 4 dat_rd pulses.
- REQ-031 hs_req and dat_req raised the same cycle -> handshake packet first, then data packet without deasserting dat_req.
- REQ-032 rx_active held high 10 cycles after a request -> no tx_valid until TURNAROUND cycles after it falls.
- REQ-033 usb_reset pulsed after the 2nd payload byte -> tx_valid low next cycle, IDLE, no dat_done; a fresh request then completes normally.
